// File: rtl/regfile_pkg.sv
// Shared types and default sizing for the multi-port register file.
package regfile_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } clr_state_t;

    localparam int DEF_DATA_W   = 16;
    localparam int DEF_ADDR_W   = 4;
    localparam int DEF_NUM_REGS = 16;

endpackage

// File: rtl/register_file_mp_if.sv
// Bus bundle between decode/writeback (master) and the register file (slave).
// Handshake: no valid/ready; wr_en/lock_en are single-cycle strobes sampled at posedge,
// and are silently dropped while busy is high.
interface register_file_mp_if
    import regfile_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ADDR_W = DEF_ADDR_W
);
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic [ADDR_W-1:0] rd_addr_a;
    logic [DATA_W-1:0] rd_data_a;
    logic [ADDR_W-1:0] rd_addr_b;
    logic [DATA_W-1:0] rd_data_b;
    logic              lock_en;
    logic [ADDR_W-1:0] lock_addr;
    logic              pend_a;
    logic              pend_b;
    logic              clr_req;
    logic              busy;
    clr_state_t        dbg_state;

    modport master (
        output wr_en, wr_addr, wr_data, rd_addr_a, rd_addr_b, lock_en, lock_addr, clr_req,
        input  rd_data_a, rd_data_b, pend_a, pend_b, busy, dbg_state
    );

    modport slave (
        input  wr_en, wr_addr, wr_data, rd_addr_a, rd_addr_b, lock_en, lock_addr, clr_req,
        output rd_data_a, rd_data_b, pend_a, pend_b, busy, dbg_state
    );
endinterface

// File: rtl/regfile_clear_seq.sv
// Clear engine: walks reg[0..NUM_REGS-1] writing zero, one register per cycle,
// after reset or a clr_req from IDLE.
module regfile_clear_seq
    import regfile_pkg::*;
#(
    parameter int ADDR_W   = DEF_ADDR_W,
    parameter int NUM_REGS = DEF_NUM_REGS
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_clr_req,
    output logic              o_busy,
    output logic              o_clr_we,
    output logic [ADDR_W-1:0] o_clr_addr,
    output logic              o_clr_start,
    output clr_state_t        o_state
);
    localparam int CNT_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

    clr_state_t       r_state;
    clr_state_t       w_next_state;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_next_cnt;
    logic             w_start;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= CLEAR;
            r_cnt   <= '0;
        end else begin
            r_state <= w_next_state;
            r_cnt   <= w_next_cnt;
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_next_cnt   = r_cnt;
        w_start      = 1'b0;
        case (r_state)
            IDLE: begin
                if (i_clr_req) begin
                    w_next_state = CLEAR;
                    w_next_cnt   = '0;
                    w_start      = 1'b1;
                end
            end
            CLEAR: begin
                // Leave on the edge that zeroes the last register: busy lasts NUM_REGS cycles.
                if (r_cnt == CNT_W'(NUM_REGS - 1)) begin
                    w_next_state = IDLE;
                    w_next_cnt   = '0;
                end else begin
                    w_next_cnt = r_cnt + CNT_W'(1);
                end
            end
            default: begin
                w_next_state = CLEAR;
                w_next_cnt   = '0;
            end
        endcase
    end

    assign o_busy      = (r_state == CLEAR);
    assign o_clr_we    = (r_state == CLEAR);
    assign o_clr_addr  = ADDR_W'(r_cnt);
    assign o_clr_start = w_start & ~rst;
    assign o_state     = r_state;

endmodule

// File: rtl/register_file_mp.sv
// Two-read / one-write register file with optional zero register, write bypass,
// per-register pending scoreboard and a sequenced clear engine.
module register_file_mp
    import regfile_pkg::*;
#(
    parameter int DATA_W   = DEF_DATA_W,
    parameter int ADDR_W   = DEF_ADDR_W,
    parameter int NUM_REGS = DEF_NUM_REGS,
    parameter int ZERO_REG = 0,
    parameter int BYPASS   = 1
) (
    input  logic                clk,
    input  logic                rst,
    register_file_mp_if.slave   bus
);
    logic [DATA_W-1:0]   r_regs [NUM_REGS];
    logic [NUM_REGS-1:0] r_pend;

    logic              w_busy;
    logic              w_clr_we;
    logic [ADDR_W-1:0] w_clr_addr;
    logic              w_clr_start;
    clr_state_t        w_state;
    logic              w_wr_ok;
    logic              w_lock_ok;
    logic [DATA_W-1:0] w_rd_a;
    logic [DATA_W-1:0] w_rd_b;
    logic              w_pend_a;
    logic              w_pend_b;

    // Implemented, writable address: below NUM_REGS and not the hard-wired zero register.
    function automatic logic addr_ok(input logic [ADDR_W-1:0] a);
        return ({1'b0, a} < (ADDR_W+1)'(NUM_REGS)) && !((ZERO_REG != 0) && (a == '0));
    endfunction

    regfile_clear_seq #(
        .ADDR_W   (ADDR_W),
        .NUM_REGS (NUM_REGS)
    ) u_clear_seq (
        .clk         (clk),
        .rst         (rst),
        .i_clr_req   (bus.clr_req),
        .o_busy      (w_busy),
        .o_clr_we    (w_clr_we),
        .o_clr_addr  (w_clr_addr),
        .o_clr_start (w_clr_start),
        .o_state     (w_state)
    );

    assign w_wr_ok   = !w_busy && bus.wr_en   && addr_ok(bus.wr_addr);
    assign w_lock_ok = !w_busy && bus.lock_en && addr_ok(bus.lock_addr);

    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_REGS; i++) begin
            if (w_clr_we && (w_clr_addr == ADDR_W'(i))) begin
                r_regs[i] <= '0;
            end else if (w_wr_ok && (bus.wr_addr == ADDR_W'(i))) begin
                r_regs[i] <= bus.wr_data;
            end
        end
    end

    // A lock and a write to the same register in one cycle leave it pending.
    always_ff @(posedge clk) begin
        if (rst || w_clr_start) begin
            r_pend <= '0;
        end else begin
            for (int i = 0; i < NUM_REGS; i++) begin
                if (w_lock_ok && (bus.lock_addr == ADDR_W'(i))) begin
                    r_pend[i] <= 1'b1;
                end else if (w_wr_ok && (bus.wr_addr == ADDR_W'(i))) begin
                    r_pend[i] <= 1'b0;
                end
            end
        end
    end

    always_comb begin
        w_rd_a   = '0;
        w_rd_b   = '0;
        w_pend_a = 1'b0;
        w_pend_b = 1'b0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (addr_ok(bus.rd_addr_a) && (bus.rd_addr_a == ADDR_W'(i))) begin
                w_rd_a   = r_regs[i];
                w_pend_a = r_pend[i];
            end
            if (addr_ok(bus.rd_addr_b) && (bus.rd_addr_b == ADDR_W'(i))) begin
                w_rd_b   = r_regs[i];
                w_pend_b = r_pend[i];
            end
        end
        if ((BYPASS != 0) && w_wr_ok && (bus.wr_addr == bus.rd_addr_a)) w_rd_a = bus.wr_data;
        if ((BYPASS != 0) && w_wr_ok && (bus.wr_addr == bus.rd_addr_b)) w_rd_b = bus.wr_data;
        if (w_busy) begin
            w_rd_a   = '0;
            w_rd_b   = '0;
            w_pend_a = 1'b0;
            w_pend_b = 1'b0;
        end
    end

    assign bus.rd_data_a = w_rd_a;
    assign bus.rd_data_b = w_rd_b;
    assign bus.pend_a    = w_pend_a;
    assign bus.pend_b    = w_pend_b;
    assign bus.busy      = w_busy;
    assign bus.dbg_state = w_state;

endmodule
